// File: rtl/jzjpcc_immediate_pipe.sv
// Decode-stage immediate generator with a STAGES-deep valid/ready output pipeline.
// Optional macro JZJPCC_IMM_ZICSR_EN adds the CSR-immediate (Z) format for CSRR*I.
module jzjpcc_immediate_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [29:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_type,
    output logic [XLEN-1:0] immediate_i,
    output logic [XLEN-1:0] immediate_b,
    output logic [XLEN-1:0] immediate_j
);

    localparam logic [2:0] TypeNone = 3'd0;
    localparam logic [2:0] TypeI    = 3'd1;
    localparam logic [2:0] TypeS    = 3'd2;
    localparam logic [2:0] TypeB    = 3'd3;
    localparam logic [2:0] TypeU    = 3'd4;
    localparam logic [2:0] TypeJ    = 3'd5;

    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpOpImm  = 5'b00100;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpJal    = 5'b11011;

    // Keep the architectural bit numbering; the implied 2'b11 is never needed.
    logic [31:2] ir;
    assign ir = instruction;

    logic [XLEN-1:0] fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    assign fmt_i = {{(XLEN - 11){ir[31]}}, ir[30:20]};
    assign fmt_s = {{(XLEN - 11){ir[31]}}, ir[30:25], ir[11:7]};
    assign fmt_b = {{(XLEN - 12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign fmt_u = {{(XLEN - 31){ir[31]}}, ir[30:12], 12'b0};
    assign fmt_j = {{(XLEN - 20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

`ifdef JZJPCC_IMM_ZICSR_EN
    localparam logic [2:0] TypeZ    = 3'd6;
    localparam logic [4:0] OpSystem = 5'b11100;
    logic [XLEN-1:0] fmt_z;
    assign fmt_z = {{(XLEN - 5){1'b0}}, ir[19:15]};
`endif

    logic [XLEN-1:0] sel_imm;
    logic [2:0]      sel_type;

    always_comb begin
        sel_imm  = '0;
        sel_type = TypeNone;
        case (ir[6:2])
            OpLoad, OpOpImm, OpJalr: begin
                sel_imm  = fmt_i;
                sel_type = TypeI;
            end
            OpStore: begin
                sel_imm  = fmt_s;
                sel_type = TypeS;
            end
            OpBranch: begin
                sel_imm  = fmt_b;
                sel_type = TypeB;
            end
            OpLui, OpAuipc: begin
                sel_imm  = fmt_u;
                sel_type = TypeU;
            end
            OpJal: begin
                sel_imm  = fmt_j;
                sel_type = TypeJ;
            end
`ifdef JZJPCC_IMM_ZICSR_EN
            OpSystem: begin
                if (ir[14]) begin
                    sel_imm  = fmt_z;
                    sel_type = TypeZ;
                end
            end
`endif
            default: ;
        endcase
    end

    logic [STAGES-1:0]           vld_q, vld_d;
    logic [STAGES-1:0][XLEN-1:0] imm_q, imm_d;
    logic [STAGES-1:0][XLEN-1:0] ii_q, ii_d;
    logic [STAGES-1:0][XLEN-1:0] ib_q, ib_d;
    logic [STAGES-1:0][XLEN-1:0] ij_q, ij_d;
    logic [STAGES-1:0][2:0]      typ_q, typ_d;

    logic [STAGES:0]   room;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    // room[k]: stage k can take a new entry this cycle; evaluated from the output backwards.
    always_comb begin
        room         = '0;
        adv          = '0;
        room[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k]  = vld_q[k] & room[k+1];
            room[k] = ~vld_q[k] | adv[k];
        end
    end

    assign in_ready = room[0];

    always_comb begin
        load    = '0;
        load[0] = in_valid & room[0] & ~flush;
        for (int k = 1; k < int'(STAGES); k++) begin
            load[k] = adv[k-1];
        end
    end

    always_comb begin
        vld_d = '0;
        imm_d = imm_q;
        ii_d  = ii_q;
        ib_d  = ib_q;
        ij_d  = ij_q;
        typ_d = typ_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            vld_d[k] = load[k] | (vld_q[k] & ~adv[k]);
        end
        if (flush) begin
            vld_d = '0;
        end
        if (load[0]) begin
            imm_d[0] = sel_imm;
            ii_d[0]  = fmt_i;
            ib_d[0]  = fmt_b;
            ij_d[0]  = fmt_j;
            typ_d[0] = sel_type;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (load[k]) begin
                imm_d[k] = imm_q[k-1];
                ii_d[k]  = ii_q[k-1];
                ib_d[k]  = ib_q[k-1];
                ij_d[k]  = ij_q[k-1];
                typ_d[k] = typ_q[k-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            imm_q <= '0;
            ii_q  <= '0;
            ib_q  <= '0;
            ij_q  <= '0;
            typ_q <= '0;
        end else begin
            vld_q <= vld_d;
            imm_q <= imm_d;
            ii_q  <= ii_d;
            ib_q  <= ib_d;
            ij_q  <= ij_d;
            typ_q <= typ_d;
        end
    end

    assign out_valid   = vld_q[STAGES-1];
    assign immediate   = imm_q[STAGES-1];
    assign imm_type    = typ_q[STAGES-1];
    assign immediate_i = ii_q[STAGES-1];
    assign immediate_b = ib_q[STAGES-1];
    assign immediate_j = ij_q[STAGES-1];

endmodule
